ball_motion: RTL



---
 rtl/ball_pkg.sv | 41 ++++
 rtl/ball_motion_axis_step.sv | 46 ++++
 rtl/ball_motion.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ball_pkg.sv
// ball_pkg: shared types and constants for the ball motion engine.
//   motion_state_t   - update sequencer states
//   ADDR_*           - Avalon register indices
//   RESET_*          - power-on position and velocity
//   abs_sat          - saturating magnitude of a signed 8-bit velocity
package ball_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC_X = 2'd1,
    CALC_Y = 2'd2,
    COMMIT = 2'd3
  } motion_state_t;

  localparam logic [2:0] ADDR_CTRL = 3'd0;
  localparam logic [2:0] ADDR_DX   = 3'd1;
  localparam logic [2:0] ADDR_DY   = 3'd2;
  localparam logic [2:0] ADDR_XL   = 3'd3;
  localparam logic [2:0] ADDR_XH   = 3'd4;
  localparam logic [2:0] ADDR_YL   = 3'd5;
  localparam logic [2:0] ADDR_YH   = 3'd6;

  localparam logic [10:0]       RESET_X  = 11'd400;
  localparam logic [9:0]        RESET_Y  = 10'd300;
  localparam logic signed [7:0] RESET_DX = 8'sd2;
  localparam logic signed [7:0] RESET_DY = 8'sd1;

  // |v| with -128 mapped to +127 so the result always fits in 8 signed bits
  function automatic logic signed [7:0] abs_sat(input logic signed [7:0] v);
    logic signed [7:0] r;
    if (v == -8'sd128) begin
      r = 8'sd127;
    end else if (v < 8'sd0) begin
      r = 8'sd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/ball_motion_axis_step.sv
// axis_step: one combinational position/velocity step with edge bounce.
//   pos     in  11  current position (zero-extended for the Y axis)
//   v       in  8   signed velocity
//   lo, hi  in  11  inclusive position limits
//   new_pos out 11  clamped position
//   new_v   out 8   velocity after a possible reflection
//   bounce  out 1   a clamp occurred
module axis_step
  import ball_pkg::*;
(
  input  logic [10:0]       pos,
  input  logic signed [7:0] v,
  input  logic [10:0]       lo,
  input  logic [10:0]       hi,
  output logic [10:0]       new_pos,
  output logic signed [7:0] new_v,
  output logic              bounce
);

  logic signed [12:0] sum;
  logic signed [12:0] lo_s;
  logic signed [12:0] hi_s;
  logic signed [7:0]  mag;

  // 13-bit signed add and clamp; a position already outside the limits clamps even with v=0
  always_comb begin
    sum  = $signed({2'b00, pos}) + $signed({{5{v[7]}}, v});
    lo_s = $signed({2'b00, lo});
    hi_s = $signed({2'b00, hi});
    mag  = abs_sat(v);
    if (sum > hi_s) begin
      new_pos = hi;
      new_v   = 8'sd0 - mag;
      bounce  = 1'b1;
    end else if (sum < lo_s) begin
      new_pos = lo;
      new_v   = mag;
      bounce  = 1'b1;
    end else begin
      new_pos = sum[10:0];
      new_v   = v;
      bounce  = 1'b0;
    end
  end

endmodule

// File: rtl/ball_motion.sv
// ball_motion: once per frame (VS falling edge) advances the ball by its
// velocity and bounces off the visible-area edges; Avalon write-only regs.
//   clk, reset                              clock, sync active-high reset
//   writedata, write, chipselect, address   Avalon slave write port
//   VGA_VS                                  active-low vertical sync
//   ball_x, ball_y                          ball centre position
//   bounce_x, bounce_y                      one-cycle clamp pulses (COMMIT cycle)
//   busy                                    update in progress
module ball_motion
  import ball_pkg::*;
#(
  parameter int BALL_SIZE = 10,
  parameter int X_MAX     = 1279,
  parameter int Y_MAX     = 479
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  writedata,
  input  logic        write,
  input  logic        chipselect,
  input  logic [2:0]  address,
  input  logic        VGA_VS,
  output logic [10:0] ball_x,
  output logic [9:0]  ball_y,
  output logic        bounce_x,
  output logic        bounce_y,
  output logic        busy
);

  motion_state_t     state, state_nx;
  logic              vs_d, tick, wr_en, start;
  logic              run, step, run_nx, step_nx;
  logic signed [7:0] dx, dy, dx_nx, dy_nx;
  logic [10:0]       ball_x_nx;
  logic [9:0]        ball_y_nx;

  // shadow results held between the CALC steps and COMMIT
  logic [10:0]       x_new;
  logic [9:0]        y_new;
  logic signed [7:0] dx_new, dy_new;
  logic              bx_flag;

  // shared axis stepper operands/results
  logic [10:0]       ax_pos, ax_lo, ax_hi, ax_new_pos;
  logic signed [7:0] ax_v, ax_new_v;
  logic              ax_bounce;

  assign tick  = vs_d & ~VGA_VS;
  assign wr_en = chipselect & write;
  assign start = (state == IDLE) && tick && (run || step);

  // VS edge detector
  always_ff @(posedge clk) begin
    vs_d <= VGA_VS;
  end

  // feed X operands to the stepper except in CALC_Y
  always_comb begin
    case (state)
      CALC_Y: begin
        ax_pos = {1'b0, ball_y};
        ax_v   = dy;
        ax_lo  = 11'(BALL_SIZE);
        ax_hi  = 11'(Y_MAX - BALL_SIZE);
      end
      default: begin
        ax_pos = ball_x;
        ax_v   = dx;
        ax_lo  = 11'(BALL_SIZE);
        ax_hi  = 11'(X_MAX - BALL_SIZE);
      end
    endcase
  end

  axis_step u_axis_step (
    .pos     (ax_pos),
    .v       (ax_v),
    .lo      (ax_lo),
    .hi      (ax_hi),
    .new_pos (ax_new_pos),
    .new_v   (ax_new_v),
    .bounce  (ax_bounce)
  );

  // sequencer next state; ticks outside IDLE are ignored
  always_comb begin
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = CALC_X;
        end else begin
          state_nx = IDLE;
        end
      end
      CALC_X:  state_nx = CALC_Y;
      CALC_Y:  state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // live register next values: COMMIT load first, then a software write on top
  // so a same-cycle write wins (byte writes keep the committed other byte)
  always_comb begin
    run_nx = run;
    dx_nx  = dx;
    dy_nx  = dy;
    if (state == COMMIT) begin
      ball_x_nx = x_new;
      ball_y_nx = y_new;
      dx_nx     = dx_new;
      dy_nx     = dy_new;
    end else begin
      ball_x_nx = ball_x;
      ball_y_nx = ball_y;
    end
    if (start) begin
      step_nx = 1'b0;
    end else begin
      step_nx = step;
    end
    if (wr_en) begin
      case (address)
        ADDR_CTRL: begin
          run_nx  = writedata[0];
          step_nx = writedata[1];
        end
        ADDR_DX: dx_nx             = $signed(writedata);
        ADDR_DY: dy_nx             = $signed(writedata);
        ADDR_XL: ball_x_nx[7:0]    = writedata;
        ADDR_XH: ball_x_nx[10:8]   = writedata[2:0];
        ADDR_YL: ball_y_nx[7:0]    = writedata;
        ADDR_YH: ball_y_nx[9:8]    = writedata[1:0];
        default: ball_x_nx         = ball_x_nx;
      endcase
    end else begin
      run_nx = run_nx;
    end
  end

  // live registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ball_x   <= RESET_X;
      ball_y   <= RESET_Y;
      dx       <= RESET_DX;
      dy       <= RESET_DY;
      run      <= 1'b0;
      step     <= 1'b0;
      busy     <= 1'b0;
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
    end else begin
      state    <= state_nx;
      ball_x   <= ball_x_nx;
      ball_y   <= ball_y_nx;
      dx       <= dx_nx;
      dy       <= dy_nx;
      run      <= run_nx;
      step     <= step_nx;
      busy     <= (state_nx != IDLE);
      // pulses land in the COMMIT cycle, the one following CALC_Y
      bounce_x <= (state == CALC_Y) && bx_flag;
      bounce_y <= (state == CALC_Y) && ax_bounce;
    end
  end

  // shadow capture of per-axis results
  always_ff @(posedge clk) begin
    if (reset) begin
      x_new   <= 11'd0;
      y_new   <= 10'd0;
      dx_new  <= 8'sd0;
      dy_new  <= 8'sd0;
      bx_flag <= 1'b0;
    end else begin
      case (state)
        CALC_X: begin
          x_new   <= ax_new_pos;
          dx_new  <= ax_new_v;
          bx_flag <= ax_bounce;
        end
        CALC_Y: begin
          y_new  <= ax_new_pos[9:0];
          dy_new <= ax_new_v;
        end
        default: begin
          x_new <= x_new;
        end
      endcase
    end
  end

endmodule
